mp_phase_gen: RTL

Synthesizable multiphase clock generator that produces `N_PH` interleaved 50%-duty phases from one fast clock. Each phase is a segment of a programmable number of cycles. The block is the clocked, parametrised successor of the behavioural 8-phase auxiliary-PLL model and sits between the reference clock domain and the multiphase consumers (phase selector / DTC front end). It adds:
- run/stop control with glitch-free drain,
- shadowed segment-length reconfiguration applied only at period boundaries,
- a frame marker.

---
 rtl/mp_pkg.sv | 20 ++
 rtl/mp_seg_counter.sv | 28 ++
 rtl/mp_phase_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mp_pkg.sv
// Shared definitions for the multiphase clock generator: FSM states, default
// geometry and the opposite-phase helper.
package mp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN
  } mp_state_e;

  localparam int MP_N_PH_DEF  = 8;
  localparam int MP_SEG_W_DEF = 8;

  // The phase half a period away from slot s; it is the one cleared when s is entered.
  function automatic int unsigned mp_opp(input int unsigned s, input int unsigned n_ph);
    return s ^ (n_ph / 2);
  endfunction

endpackage

// File: rtl/mp_seg_counter.sv
// Segment-length counter: counts up from zero and flags when it reaches the
// programmed limit; clr has priority over en.
module mp_seg_counter #(
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SEG_W-1:0] limit,
  output logic             tc
);

  logic [SEG_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + SEG_W'(1);
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/mp_phase_gen.sv
// Multiphase clock generator: N_PH interleaved 50%-duty phases built from
// programmable-length slots, with run/drain control and shadowed reconfiguration.
module mp_phase_gen
  import mp_pkg::*;
#(
  parameter int N_PH  = MP_N_PH_DEF,
  parameter int SEG_W = MP_SEG_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEG_W-1:0] seg_len,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic [N_PH-1:0]  fmp,
  output logic             frame,
  output logic             running
);

  localparam int SLOT_W = $clog2(N_PH);

  mp_state_e        state, state_next;
  logic [SLOT_W-1:0] slot, slot_next, slot_inc, opp;
  logic [N_PH-1:0]  fmp_next;
  logic [SEG_W-1:0] seg_act, seg_act_next, shadow;
  logic             pending, pending_next;
  logic             frame_next, ack_next;
  logic             cnt_clr, cnt_en, tc, run_eff;

  mp_seg_counter #(.SEG_W(SEG_W)) u_seg_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (seg_act),
    .tc    (tc)
  );

  assign slot_inc = slot + SLOT_W'(1);
  assign opp      = SLOT_W'(mp_opp(int'(slot_inc), N_PH));
  // An edge that samples en low already behaves as a drain edge: no new rises.
  assign run_eff  = (state == RUN) && en;
  assign running  = (state == RUN) || (state == DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      slot    <= '0;
      fmp     <= '0;
      frame   <= 1'b0;
      cfg_ack <= 1'b0;
      seg_act <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      slot    <= slot_next;
      fmp     <= fmp_next;
      frame   <= frame_next;
      cfg_ack <= ack_next;
      seg_act <= seg_act_next;
      pending <= pending_next;
      if (cfg_load) begin
        shadow <= seg_len;
      end
    end
  end

  always_comb begin
    state_next   = state;
    slot_next    = slot;
    fmp_next     = fmp;
    frame_next   = 1'b0;
    ack_next     = 1'b0;
    seg_act_next = seg_act;
    pending_next = pending | cfg_load;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          state_next = ARM;
          if (pending) begin
            seg_act_next = shadow;
            ack_next     = 1'b1;
            pending_next = cfg_load;
          end
        end
      end
      ARM: begin
        if (en) begin
          state_next  = RUN;
          slot_next   = '0;
          cnt_clr     = 1'b1;
          fmp_next[0] = 1'b1;
          frame_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN, DRAIN: begin
        cnt_en = 1'b1;
        if (!run_eff) begin
          state_next = DRAIN;
        end
        if (tc) begin
          cnt_clr       = 1'b1;
          slot_next     = slot_inc;
          fmp_next[opp] = 1'b0;
          if (run_eff) begin
            fmp_next[slot_inc] = 1'b1;
            // A period boundary is the only point where a new length may take effect.
            if (slot_inc == '0) begin
              frame_next = 1'b1;
              if (pending) begin
                seg_act_next = shadow;
                ack_next     = 1'b1;
                pending_next = cfg_load;
              end
            end
          end
        end
        if (!run_eff && (fmp_next == '0)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
